env_det_pwr_on_tx_9bit: RTL and testbench

Board-level top for the environment-detect node. It synchronizes and debounces the environment-detect input on PIN_1, mirrors the detected level on LED and PIN_5, and serially transmits 9-bit status frames on PIN_2. One frame is sent automatically after a power-on delay, and one more after each debounced change of the detect level. USB pull-up is held disabled.

---
 rtl/env_det_pwr_on_tx_9bit.sv | 215 +++++++++++++++++++++
 tb/tb_env_det_pwr_on_tx_9bit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/env_det_pwr_on_tx_9bit.sv
// env_det_pwr_on_tx_9bit: board-level top for the environment-detect node.
// Synchronizes and debounces PIN_1, mirrors the level on PIN_5/LED, and
// sends 9-bit {level, seq} frames on PIN_2. One frame goes out after
// power-on, and one more after each debounced level change.
//   CLK    system clock, rising edge
//   RST    synchronous active-high reset
//   PIN_1  asynchronous environment-detect input
//   PIN_2  serial TX data, idles high
//   PIN_3  TX busy, start bit through stop bit
//   PIN_4  one-cycle frame-done pulse
//   PIN_5  debounced detect level
//   PIN_6  power-on done, sticky until reset
//   LED    copy of PIN_5
//   USBPU  USB pull-up enable, held low
module env_det_pwr_on_tx_9bit #(
  parameter int unsigned PWR_ON_CYCLES   = 64,
  parameter int unsigned BIT_CYCLES      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic PIN_1,
  output logic PIN_2,
  output logic PIN_3,
  output logic PIN_4,
  output logic PIN_5,
  output logic PIN_6,
  output logic LED,
  output logic USBPU
);

  localparam int unsigned PWR_W   = $clog2(PWR_ON_CYCLES + 1);
  localparam int unsigned BIT_W   = $clog2(BIT_CYCLES + 1);
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned FRAME_W = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  logic               sync1_q, sync2_q;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               level_q, level_d;
  logic               level_chg;
  logic [PWR_W-1:0]   pwr_cnt_q;
  logic               pwr_done_q;
  logic               pwr_fire;
  logic               pending_q, pending_d;
  logic [7:0]         seq_q;
  logic               load;
  logic [FRAME_W-1:0] payload;

  tx_state_e          state_q;
  logic [BIT_W-1:0]   cyc_cnt_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [FRAME_W-1:0] shreg_q;
  logic               tx_q, busy_q, done_q;

  // Two-flop synchronizer on the asynchronous detect input
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= PIN_1;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles where the synced input disagrees
  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign level_chg = (level_d != level_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
    end
  end

  // Power-on counter; fires exactly once, on edge PWR_ON_CYCLES after release
  assign pwr_fire = !pwr_done_q && (pwr_cnt_q == PWR_W'(PWR_ON_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwr_cnt_q  <= '0;
      pwr_done_q <= 1'b0;
    end else if (!pwr_done_q) begin
      pwr_cnt_q <= pwr_cnt_q + PWR_W'(1);
      if (pwr_fire) begin
        pwr_done_q <= 1'b1;
      end
    end
  end

  // A load takes the level being written this edge, so a coincident change
  // is carried by the frame and does not leave pending set behind it.
  assign load    = (state_q == S_IDLE) && (pending_q || pwr_fire);
  assign payload = {level_d, seq_q};

  always_comb begin
    pending_d = pending_q;
    if (load) begin
      pending_d = 1'b0;
    end else if (level_chg && pwr_done_q) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_q <= 1'b0;
      seq_q     <= '0;
    end else begin
      pending_q <= pending_d;
      if (load) begin
        seq_q <= seq_q + 8'd1;
      end
    end
  end

  // Serial transmitter: start, 9 data bits LSB first, stop
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cyc_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            state_q   <= S_START;
            cyc_cnt_q <= '0;
            shreg_q   <= payload;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_START: begin
          if (cyc_cnt_q == BIT_W'(BIT_CYCLES - 1)) begin
            state_q   <= S_DATA;
            cyc_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + BIT_W'(1);
          end
        end
        S_DATA: begin
          if (cyc_cnt_q == BIT_W'(BIT_CYCLES - 1)) begin
            cyc_cnt_q <= '0;
            if (bit_idx_q == IDX_W'(FRAME_W - 1)) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              tx_q      <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
            end
          end else begin
            cyc_cnt_q <= cyc_cnt_q + BIT_W'(1);
          end
        end
        S_STOP: begin
          if (cyc_cnt_q == BIT_W'(BIT_CYCLES - 1)) begin
            state_q   <= S_IDLE;
            cyc_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + BIT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PIN_2 = tx_q;
  assign PIN_3 = busy_q;
  assign PIN_4 = done_q;
  assign PIN_5 = level_q;
  assign PIN_6 = pwr_done_q;
  assign LED   = level_q;
  assign USBPU = 1'b0;

endmodule

// File: tb/tb_env_det_pwr_on_tx_9bit.sv
// Bench for env_det_pwr_on_tx_9bit: a frame-level reference model checked
// every cycle, plus directed scenarios with literal timing expectations.
module tb_env_det_pwr_on_tx_9bit;

  localparam int PWR   = 64;
  localparam int BITC  = 16;
  localparam int DEB   = 8;
  localparam int FRAME = 11 * BITC;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic PIN_1 = 1'b0;
  logic PIN_2, PIN_3, PIN_4, PIN_5, PIN_6, LED, USBPU;

  env_det_pwr_on_tx_9bit #(
    .PWR_ON_CYCLES  (PWR),
    .BIT_CYCLES     (BITC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .PIN_1(PIN_1),
    .PIN_2(PIN_2),
    .PIN_3(PIN_3),
    .PIN_4(PIN_4),
    .PIN_5(PIN_5),
    .PIN_6(PIN_6),
    .LED  (LED),
    .USBPU(USBPU)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks frames as (start edge, payload) and derives the
  // line level from the offset into the frame.
  int         n = 0;
  bit         model_ok = 0;
  bit         m_s1, m_s2, m_lvl, m_pdone, m_pend, m_active;
  int         m_run, m_t, m_fstart, off;
  logic [8:0] m_pay;
  logic [7:0] m_seq;
  bit         s2_old, new_lvl, chg, fire, idle;
  logic       e2, e3, e4;

  always @(posedge CLK) begin
    n++;
    if (RST) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pdone = 0; m_pend = 0; m_active = 0;
      m_run = 0; m_t = 0; m_fstart = 0; m_pay = '0; m_seq = '0;
      model_ok = 1;
    end else begin
      s2_old = m_s2;
      m_s2 = m_s1;
      m_s1 = PIN_1;
      new_lvl = m_lvl;
      if (s2_old != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          new_lvl = s2_old;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      chg = (new_lvl != m_lvl);
      m_lvl = new_lvl;
      m_t++;
      fire = !m_pdone && (m_t == PWR);
      idle = !m_active || ((n - m_fstart) > FRAME);
      if (idle && (m_pend || fire)) begin
        m_active = 1;
        m_fstart = n;
        m_pay = {m_lvl, m_seq};
        m_seq = m_seq + 8'd1;
        m_pend = 0;
      end else if (chg && m_pdone) begin
        m_pend = 1;
      end
      if (fire) m_pdone = 1;
    end
    e2 = 1'b1; e3 = 1'b0; e4 = 1'b0;
    if (m_active) begin
      off = n - m_fstart;
      if (off < FRAME) begin
        e3 = 1'b1;
        if (off < BITC) e2 = 1'b0;
        else if (off < 10 * BITC) e2 = m_pay[off / BITC - 1];
        else e2 = 1'b1;
      end else if (off == FRAME) begin
        e4 = 1'b1;
      end
    end
    #1;
    if (model_ok) begin
      chk("model_PIN_2", 32'(PIN_2), 32'(e2));
      chk("model_PIN_3", 32'(PIN_3), 32'(e3));
      chk("model_PIN_4", 32'(PIN_4), 32'(e4));
      chk("model_PIN_5", 32'(PIN_5), 32'(m_lvl));
      chk("model_PIN_6", 32'(PIN_6), 32'(m_pdone));
      chk("model_LED",   32'(LED),   32'(m_lvl));
      chk("model_USBPU", 32'(USBPU), 32'd0);
    end
  end

  // Advance k rising edges, then settle just past the last one
  task automatic tick(input int k);
    repeat (k) @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
  endtask

  task automatic wait_sig(input string name, input bit use4, input int maxc);
    bit seen;
    seen = 0;
    for (int k = 0; k < maxc && !seen; k++) begin
      tick(1);
      seen = use4 ? PIN_4 : PIN_3;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  int hold;

  initial begin
    // Reset values, then power-on frame with PIN_1 low
    tick(2);
    chk("rst_PIN_2", 32'(PIN_2), 32'd1);
    chk("rst_PIN_3", 32'(PIN_3), 32'd0);
    chk("rst_PIN_4", 32'(PIN_4), 32'd0);
    chk("rst_PIN_5", 32'(PIN_5), 32'd0);
    chk("rst_PIN_6", 32'(PIN_6), 32'd0);
    RST = 1'b0;
    tick(63);
    chk("a63_PIN_6", 32'(PIN_6), 32'd0);
    chk("a63_PIN_2", 32'(PIN_2), 32'd1);
    tick(1);
    chk("a64_PIN_6", 32'(PIN_6), 32'd1);
    chk("a64_PIN_2", 32'(PIN_2), 32'd0);
    chk("a64_PIN_3", 32'(PIN_3), 32'd1);
    tick(159);
    chk("a223_D8", 32'(PIN_2), 32'd0);
    tick(1);
    chk("a224_stop", 32'(PIN_2), 32'd1);
    tick(16);
    chk("a240_PIN_4", 32'(PIN_4), 32'd1);
    chk("a240_PIN_3", 32'(PIN_3), 32'd0);
    tick(1);
    chk("a241_PIN_4", 32'(PIN_4), 32'd0);

    // PIN_1 high from reset: level at cycle 10, payload 9'h100
    PIN_1 = 1'b1;
    do_reset();
    tick(9);
    chk("b9_PIN_5", 32'(PIN_5), 32'd0);
    tick(1);
    chk("b10_PIN_5", 32'(PIN_5), 32'd1);
    chk("b10_LED", 32'(LED), 32'd1);
    tick(197);
    chk("b207_D7", 32'(PIN_2), 32'd0);
    tick(1);
    chk("b208_D8", 32'(PIN_2), 32'd1);
    tick(32);
    chk("b240_PIN_4", 32'(PIN_4), 32'd1);
    tick(4);
    PIN_1 = 1'b0;
    tick(9);
    chk("b253_PIN_5", 32'(PIN_5), 32'd1);
    tick(1);
    chk("b254_PIN_5", 32'(PIN_5), 32'd0);
    chk("b254_PIN_3", 32'(PIN_3), 32'd0);
    tick(1);
    chk("b255_start", 32'(PIN_2), 32'd0);
    chk("b255_PIN_3", 32'(PIN_3), 32'd1);
    tick(16);
    chk("b271_D0", 32'(PIN_2), 32'd1);
    tick(16);
    chk("b287_D1", 32'(PIN_2), 32'd0);
    tick(170);

    // Short glitch while idle: no level change, no frame
    PIN_1 = 1'b1;
    tick(5);
    PIN_1 = 1'b0;
    tick(30);
    chk("c_glitch_PIN_5", 32'(PIN_5), 32'd0);
    chk("c_glitch_PIN_3", 32'(PIN_3), 32'd0);

    // Two debounced changes during one frame -> exactly one follow-up frame
    PIN_1 = 1'b1;
    wait_sig("d_frame_start", 1'b0, 40);
    tick(30);
    PIN_1 = 1'b0;
    tick(30);
    PIN_1 = 1'b1;
    tick(30);
    wait_sig("d_done", 1'b1, 300);
    tick(1);
    chk("d_next_PIN_3", 32'(PIN_3), 32'd1);
    chk("d_next_PIN_2", 32'(PIN_2), 32'd0);
    tick(FRAME + 30);
    chk("d_no_third", 32'(PIN_3), 32'd0);

    // Reset mid-frame at cycle 150
    PIN_1 = 1'b0;
    do_reset();
    tick(149);
    RST = 1'b1;
    tick(1);
    chk("e_rst_PIN_2", 32'(PIN_2), 32'd1);
    chk("e_rst_PIN_3", 32'(PIN_3), 32'd0);
    chk("e_rst_PIN_6", 32'(PIN_6), 32'd0);
    RST = 1'b0;
    tick(63);
    chk("e63_PIN_3", 32'(PIN_3), 32'd0);
    tick(1);
    chk("e64_PIN_3", 32'(PIN_3), 32'd1);
    chk("e64_PIN_2", 32'(PIN_2), 32'd0);

    // Randomized detect activity with occasional resets
    for (int r = 0; r < 120; r++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      PIN_1 = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 60));
      tick(hold);
    end
    tick(FRAME * 2 + 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
